// File: rtl/ulpb_layer_ctrl.sv
// ulpb_layer_ctrl: host-side link-layer controller for a ULPB node
//   transmit path: accepts one host message, requests the node to send it,
//   waits for the receiver ACK with a timeout and retries up to MAX_RETRY times.
//   receive path: single-entry buffer between the node and the host with a
//   REQ/ACK handshake toward the node and VALID/READY toward the host.
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_tx_valid/i_tx_addr/i_tx_data     host message in; o_tx_ready accepts it
//   o_tx_done/o_tx_fail                one-cycle result pulses
//   o_addr_in/o_data_in/o_req_tx       transmit request to the node
//   i_ack_tx/i_ack_received            node accepted request / receiver ACK seen
//   i_req_rx/i_addr_out/i_data_out     received message from the node
//   o_ack_rx                           receive acknowledge to the node
//   o_rx_valid/o_rx_addr/o_rx_data     buffered message to host; i_rx_ready consumes
module ulpb_layer_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_RETRY   = 3,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_tx_valid,
    input  logic [ADDR_WIDTH-1:0] i_tx_addr,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    output logic                  o_tx_ready,
    output logic                  o_tx_done,
    output logic                  o_tx_fail,
    output logic [ADDR_WIDTH-1:0] o_addr_in,
    output logic [DATA_WIDTH-1:0] o_data_in,
    output logic                  o_req_tx,
    input  logic                  i_ack_tx,
    input  logic                  i_ack_received,
    input  logic                  i_req_rx,
    input  logic [ADDR_WIDTH-1:0] i_addr_out,
    input  logic [DATA_WIDTH-1:0] i_data_out,
    output logic                  o_ack_rx,
    output logic                  o_rx_valid,
    output logic [ADDR_WIDTH-1:0] o_rx_addr,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    input  logic                  i_rx_ready
);
    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_LD = CW'(ACK_TIMEOUT);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    typedef enum logic [1:0] {T_IDLE, T_REQ, T_RELEASE, T_WAIT_ACK} tx_state_t;
    typedef enum logic {R_IDLE, R_ACK} rx_state_t;

    tx_state_t             r_tx_state;
    rx_state_t             r_rx_state;
    logic [CW-1:0]         r_cnt;
    logic [RW-1:0]         r_retry;
    logic                  r_tx_done;
    logic                  r_tx_fail;
    logic                  r_req_tx;
    logic [ADDR_WIDTH-1:0] r_addr_in;
    logic [DATA_WIDTH-1:0] r_data_in;
    logic                  r_ack_rx;
    logic                  r_rx_valid;
    logic [ADDR_WIDTH-1:0] r_rx_addr;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  w_consume;

    assign w_consume  = r_rx_valid & i_rx_ready;
    assign o_tx_ready = (r_tx_state == T_IDLE);
    assign o_tx_done  = r_tx_done;
    assign o_tx_fail  = r_tx_fail;
    assign o_req_tx   = r_req_tx;
    assign o_addr_in  = r_addr_in;
    assign o_data_in  = r_data_in;
    assign o_ack_rx   = r_ack_rx;
    assign o_rx_valid = r_rx_valid;
    assign o_rx_addr  = r_rx_addr;
    assign o_rx_data  = r_rx_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_state <= T_IDLE;
            r_cnt      <= '0;
            r_retry    <= '0;
            r_tx_done  <= 1'b0;
            r_tx_fail  <= 1'b0;
            r_req_tx   <= 1'b0;
            r_addr_in  <= '0;
            r_data_in  <= '0;
        end else begin
            r_tx_done <= 1'b0;
            r_tx_fail <= 1'b0;
            case (r_tx_state)
                T_IDLE: if (i_tx_valid) begin
                    r_addr_in  <= i_tx_addr;
                    r_data_in  <= i_tx_data;
                    r_retry    <= '0;
                    r_req_tx   <= 1'b1;
                    r_tx_state <= T_REQ;
                end
                T_REQ: if (i_ack_tx) begin
                    r_req_tx   <= 1'b0;
                    r_tx_state <= T_RELEASE;
                end
                T_RELEASE: if (!i_ack_tx) begin
                    r_cnt      <= TIMEOUT_LD;
                    r_tx_state <= T_WAIT_ACK;
                end
                T_WAIT_ACK: begin
                    // The result pulse is shown while still busy so that
                    // TX_READY only rises the cycle after the pulse.
                    if (r_tx_done | r_tx_fail)
                        r_tx_state <= T_IDLE;
                    else if (i_ack_received)
                        r_tx_done <= 1'b1;
                    else if (r_cnt != '0)
                        r_cnt <= r_cnt - 1'b1;
                    else if (r_retry < RETRY_MAX) begin
                        r_retry    <= r_retry + 1'b1;
                        r_req_tx   <= 1'b1;
                        r_tx_state <= T_REQ;
                    end else
                        r_tx_fail <= 1'b1;
                end
                default: r_tx_state <= T_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_state <= R_IDLE;
            r_ack_rx   <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_addr  <= '0;
            r_rx_data  <= '0;
        end else begin
            case (r_rx_state)
                R_IDLE: begin
                    // A slot being consumed this cycle counts as free.
                    if (i_req_rx && (!r_rx_valid || w_consume)) begin
                        r_rx_addr  <= i_addr_out;
                        r_rx_data  <= i_data_out;
                        r_rx_valid <= 1'b1;
                        r_ack_rx   <= 1'b1;
                        r_rx_state <= R_ACK;
                    end else if (w_consume)
                        r_rx_valid <= 1'b0;
                end
                R_ACK: begin
                    if (!i_req_rx) begin
                        r_ack_rx   <= 1'b0;
                        r_rx_state <= R_IDLE;
                    end
                    if (w_consume)
                        r_rx_valid <= 1'b0;
                end
                default: r_rx_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ulpb_layer_ctrl.sv
// tb_ulpb_layer_ctrl: randomized and directed bench for ulpb_layer_ctrl
//   a transaction-level reference model predicts every output each cycle;
//   directed scenarios pin the model with hand-computed cycle numbers.
module tb_ulpb_layer_ctrl;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MR = 3;
    localparam int AT = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_valid, ack_tx, ack_received, req_rx, rx_ready;
    logic [AW-1:0] tx_addr, addr_out;
    logic [DW-1:0] tx_data, data_out;
    logic          o_tx_ready, o_tx_done, o_tx_fail, o_req_tx, o_ack_rx, o_rx_valid;
    logic [AW-1:0] o_addr_in, o_rx_addr;
    logic [DW-1:0] o_data_in, o_rx_data;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    // reference model state
    bit          m_busy, m_req, m_rel, m_done, m_fail, m_rv, m_ack, mc;
    int          m_waited, m_tries;
    logic [AW-1:0] m_addr, m_ra;
    logic [DW-1:0] m_data, m_rd;

    ulpb_layer_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_RETRY(MR), .ACK_TIMEOUT(AT)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_tx_valid(tx_valid), .i_tx_addr(tx_addr), .i_tx_data(tx_data),
        .o_tx_ready(o_tx_ready), .o_tx_done(o_tx_done), .o_tx_fail(o_tx_fail),
        .o_addr_in(o_addr_in), .o_data_in(o_data_in), .o_req_tx(o_req_tx),
        .i_ack_tx(ack_tx), .i_ack_received(ack_received),
        .i_req_rx(req_rx), .i_addr_out(addr_out), .i_data_out(data_out),
        .o_ack_rx(o_ack_rx), .o_rx_valid(o_rx_valid), .o_rx_addr(o_rx_addr),
        .o_rx_data(o_rx_data), .i_rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Model: one transmission attempt = request until ACK_TX, release until
    // ACK_TX drops, then ACK_TIMEOUT+1 cycles of waiting for the receiver ACK.
    task automatic model_step();
        if (rst) begin
            m_busy = 0; m_req = 0; m_rel = 0; m_done = 0; m_fail = 0;
            m_waited = 0; m_tries = 0; m_addr = '0; m_data = '0;
            m_rv = 0; m_ack = 0; m_ra = '0; m_rd = '0;
        end else begin
            if (m_done || m_fail) begin
                m_done = 0; m_fail = 0; m_busy = 0;
            end else if (!m_busy) begin
                if (tx_valid) begin
                    m_addr = tx_addr; m_data = tx_data;
                    m_busy = 1; m_req = 1; m_tries = 1;
                end
            end else if (m_req) begin
                if (ack_tx) begin m_req = 0; m_rel = 1; end
            end else if (m_rel) begin
                if (!ack_tx) begin m_rel = 0; m_waited = 0; end
            end else if (ack_received) m_done = 1;
            else if (m_waited < AT) m_waited++;
            else if (m_tries <= MR) begin m_tries++; m_req = 1; end
            else m_fail = 1;
            mc = m_rv && rx_ready;
            if (m_ack) begin
                if (!req_rx) m_ack = 0;
                if (mc) m_rv = 0;
            end else if (req_rx && (!m_rv || mc)) begin
                m_ra = addr_out; m_rd = data_out; m_rv = 1; m_ack = 1;
            end else if (mc) m_rv = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("tx_ready", 64'(o_tx_ready), 64'(!m_busy));
            chk("tx_done",  64'(o_tx_done),  64'(m_done));
            chk("tx_fail",  64'(o_tx_fail),  64'(m_fail));
            chk("req_tx",   64'(o_req_tx),   64'(m_req));
            chk("addr_in",  64'(o_addr_in),  64'(m_addr));
            chk("data_in",  64'(o_data_in),  64'(m_data));
            chk("ack_rx",   64'(o_ack_rx),   64'(m_ack));
            chk("rx_valid", 64'(o_rx_valid), 64'(m_rv));
            chk("rx_addr",  64'(o_rx_addr),  64'(m_ra));
            chk("rx_data",  64'(o_rx_data),  64'(m_rd));
        end
    end

    task automatic run_tx(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit echo,
                          input int ack_at, input int n, output int rises, output int fails,
                          output int dones, output int fail_k, output int done_k, output int rdy_k);
        bit prev = 0;
        rises = 0; fails = 0; dones = 0; fail_k = 0; done_k = 0; rdy_k = 0;
        tx_valid = 1; tx_addr = a; tx_data = d;
        tick();
        tx_valid = 0;
        for (int k = 1; k <= n; k++) begin
            if (o_req_tx && !prev) rises++;
            prev = o_req_tx;
            if (o_tx_done) begin dones++; done_k = k; end
            if (o_tx_fail) begin fails++; fail_k = k; end
            if (o_tx_ready && rdy_k == 0) rdy_k = k;
            ack_tx = echo ? o_req_tx : (k == 2);
            ack_received = (k == ack_at);
            tick();
        end
        ack_tx = 0; ack_received = 0;
    endtask

    initial begin
        int rises, fails, dones, fail_k, done_k, rdy_k, pulses;
        rst = 1; tx_valid = 0; ack_tx = 0; ack_received = 0; req_rx = 0; rx_ready = 0;
        tx_addr = '0; tx_data = '0; addr_out = '0; data_out = '0;
        tick();
        chk_on = 1;
        chk("rst_tx_ready", 64'(o_tx_ready), 64'd1);
        chk("rst_req_tx", 64'(o_req_tx), 64'd0);
        chk("rst_rx_valid", 64'(o_rx_valid), 64'd0);
        chk("rst_addr_in", 64'(o_addr_in), 64'd0);
        tick();
        rst = 0;
        tick();

        // acknowledged message, ACK_TX in cycle 2, ACK_RECEIVED in cycle 10
        run_tx(8'hAB, 32'h12345678, 0, 10, 14, rises, fails, dones, fail_k, done_k, rdy_k);
        chk("ok_addr_in", 64'(o_addr_in), 64'hAB);
        chk("ok_data_in", 64'(o_data_in), 64'h12345678);
        chk("ok_req_rises", 64'(rises), 64'd1);
        chk("ok_dones", 64'(dones), 64'd1);
        chk("ok_fails", 64'(fails), 64'd0);
        chk("ok_done_cycle", 64'(done_k), 64'd11);
        chk("ok_ready_cycle", 64'(rdy_k), 64'd12);

        // no receiver ACK ever: 4 attempts, period AT+3 = 12 cycles
        run_tx(8'h42, 32'hCAFEF00D, 1, 0, 55, rises, fails, dones, fail_k, done_k, rdy_k);
        chk("to_req_rises", 64'(rises), 64'd4);
        chk("to_fails", 64'(fails), 64'd1);
        chk("to_dones", 64'(dones), 64'd0);
        chk("to_fail_cycle", 64'(fail_k), 64'd49);
        chk("to_ready_cycle", 64'(rdy_k), 64'd50);

        // receiver ACK on the exact expiry cycle wins
        run_tx(8'h17, 32'h0BADF00D, 1, 12, 16, rises, fails, dones, fail_k, done_k, rdy_k);
        chk("edge_req_rises", 64'(rises), 64'd1);
        chk("edge_fails", 64'(fails), 64'd0);
        chk("edge_done_cycle", 64'(done_k), 64'd13);
        chk("edge_ready_cycle", 64'(rdy_k), 64'd14);

        // receive with backpressure and simultaneous consume+capture
        req_rx = 1; addr_out = 8'h5C; data_out = 32'hDEADBEEF;
        tick();
        chk("rx1_valid", 64'(o_rx_valid), 64'd1);
        chk("rx1_addr", 64'(o_rx_addr), 64'h5C);
        chk("rx1_data", 64'(o_rx_data), 64'hDEADBEEF);
        chk("rx1_ack", 64'(o_ack_rx), 64'd1);
        tick(); tick();
        chk("rx1_ack_held", 64'(o_ack_rx), 64'd1);
        req_rx = 0;
        tick();
        chk("rx1_ack_drop", 64'(o_ack_rx), 64'd0);
        req_rx = 1; addr_out = 8'h33; data_out = 32'h01234567;
        tick(); tick(); tick();
        chk("rx2_backpressure", 64'(o_ack_rx), 64'd0);
        chk("rx2_old_addr", 64'(o_rx_addr), 64'h5C);
        rx_ready = 1;
        tick();
        rx_ready = 0;
        chk("rx2_valid", 64'(o_rx_valid), 64'd1);
        chk("rx2_addr", 64'(o_rx_addr), 64'h33);
        chk("rx2_data", 64'(o_rx_data), 64'h01234567);
        chk("rx2_ack", 64'(o_ack_rx), 64'd1);
        req_rx = 0;
        tick();
        rx_ready = 1;
        tick();
        rx_ready = 0;
        chk("rx2_consumed", 64'(o_rx_valid), 64'd0);

        // reset while waiting for the receiver ACK and while acking a receive
        tx_valid = 1; tx_addr = 8'h99; tx_data = 32'h55AA55AA; req_rx = 1; addr_out = 8'h77;
        tick();
        tx_valid = 0; ack_tx = 1;
        tick();
        ack_tx = 0;
        tick(); tick();
        rst = 1;
        tick();
        rst = 0; req_rx = 0;
        chk("mid_rst_ready", 64'(o_tx_ready), 64'd1);
        chk("mid_rst_req_tx", 64'(o_req_tx), 64'd0);
        chk("mid_rst_ack_rx", 64'(o_ack_rx), 64'd0);
        chk("mid_rst_rx_valid", 64'(o_rx_valid), 64'd0);
        chk("mid_rst_addr_in", 64'(o_addr_in), 64'd0);
        chk("mid_rst_rx_addr", 64'(o_rx_addr), 64'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            pulses += int'(o_tx_done) + int'(o_tx_fail);
            tick();
        end
        chk("mid_rst_no_pulse", 64'(pulses), 64'd0);

        // randomized traffic on both paths
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            tx_valid = ($urandom_range(0, 2) == 0);
            tx_addr = AW'($urandom);
            tx_data = DW'($urandom);
            ack_tx = ($urandom_range(0, 3) != 0) ? o_req_tx : 1'($urandom);
            ack_received = ($urandom_range(0, 15) == 0);
            req_rx = ($urandom_range(0, 2) != 0);
            addr_out = AW'($urandom);
            data_out = DW'($urandom);
            rx_ready = 1'($urandom);
            tick();
        end
        rst = 0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
